// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS multiply/divide unit with HI/LO registers
//
// Purpose:
//   Executes MULT/MULTU/DIV/DIVU as a 32-iteration shift-add multiply or
//   restoring divide, followed by one sign-fix cycle. MTHI/MTLO write HI/LO
//   directly in a single cycle.
//
// Optional feature:
//   MULDIV_FAST_MULT_EN - when defined, MULT/MULTU are computed
//   combinationally and written at the accepting edge; divide is unchanged.
//
// Ports:
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   start        in   operation request, sampled only while busy=0
//   op[2:0]      in   000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO
//   in_s1        in   multiplicand / dividend / MTHI-MTLO source
//   in_s2        in   multiplier / divisor
//   busy         out  iterative operation in flight
//   done         out  one-cycle pulse when HI/LO hold a new result
//   div_by_zero  out  last divide had a zero divisor
//   hi, lo       out  architectural HI/LO registers
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_s1,
  input  logic [WIDTH-1:0] in_s2,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = 6;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      cnt_q;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q;      // multiplicand or divisor magnitude
  logic               is_div_q;
  logic               neg_res_q;  // negate product / quotient
  logic               neg_rem_q;  // negate remainder (dividend was negative)
  logic               dz_q;
  logic               done_q;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic idle, req_mul, req_div, req_mt, accept_iter;

  assign idle    = (state_q == S_IDLE);
  assign req_mul = idle & start & (op[2:1] == 2'b00);
  assign req_div = idle & start & (op[2:1] == 2'b01);
  assign req_mt  = idle & start & (op[2:1] == 2'b10);

`ifdef MULDIV_FAST_MULT_EN
  logic accept_fast;
  assign accept_iter = req_div;
  assign accept_fast = req_mul;
`else
  assign accept_iter = req_mul | req_div;
`endif

  // Signed ops (op[0]=1) work on magnitudes; signs are re-applied in FIX.
  logic             s1_neg, s2_neg;
  logic [WIDTH-1:0] s1_mag, s2_mag;

  assign s1_neg = op[0] & in_s1[WIDTH-1];
  assign s2_neg = op[0] & in_s2[WIDTH-1];
  assign s1_mag = s1_neg ? -in_s1 : in_s1;
  assign s2_mag = s2_neg ? -in_s2 : in_s2;

`ifdef MULDIV_FAST_MULT_EN
  // Sign-extending to 2*WIDTH makes the truncated product correct for
  // both signed and unsigned operands.
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{s1_neg}}, in_s1} * {{WIDTH{s2_neg}}, in_s2};
`endif

  // ---------------------------------------------------------------------
  // One iteration of the datapath
  // ---------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_fits;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opb_q};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    // No borrow out of the top bit means the divisor fits.
    div_fits  = ~div_diff[WIDTH];
    if (is_div_q) begin
      acc_step = {(div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], div_fits};
    end else begin
      // Carry out of the add becomes the new top bit after the shift.
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------
  // Sign correction applied in FIX
  // ---------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix, res_hi, res_lo;

  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
    // A zero divisor leaves the restoring loop with an all-ones quotient and
    // the dividend magnitude as remainder; re-signing the remainder yields
    // the dividend exactly as it was presented.
    quo_fix  = dz_q ? {WIDTH{1'b1}} : (neg_res_q ? -quo : quo);
    rem_fix  = neg_rem_q ? -rem : rem;
    if (is_div_q) begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_iter) state_d = S_RUN;
      S_RUN:   if (cnt_q == CNT_LAST) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs (both come straight from flops)
  always_comb begin
    busy = (state_q != S_IDLE);
    done = done_q;
  end

  // ---------------------------------------------------------------------
  // Iteration datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else if (accept_iter) begin
      cnt_q     <= '0;
      is_div_q  <= op[1];
      neg_res_q <= s1_neg ^ s2_neg;
      neg_rem_q <= s1_neg;
      dz_q      <= op[1] & (in_s2 == '0);
      if (op[1]) begin
        acc_q <= {{WIDTH{1'b0}}, s1_mag};
        opb_q <= s2_mag;
      end else begin
        acc_q <= {{WIDTH{1'b0}}, s2_mag};
        opb_q <= s1_mag;
      end
    end else if (state_q == S_RUN) begin
      cnt_q <= cnt_q + CNT_ONE;
      acc_q <= acc_step;
    end
  end

  // ---------------------------------------------------------------------
  // Architectural HI/LO, div_by_zero and done
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_FIX) begin
        hi          <= res_hi;
        lo          <= res_lo;
        div_by_zero <= dz_q;
        done_q      <= 1'b1;
      end else if (accept_iter) begin
        div_by_zero <= 1'b0;
`ifdef MULDIV_FAST_MULT_EN
      end else if (accept_fast) begin
        hi          <= fast_prod[2*WIDTH-1:WIDTH];
        lo          <= fast_prod[WIDTH-1:0];
        div_by_zero <= 1'b0;
        done_q      <= 1'b1;
`endif
      end else if (req_mt) begin
        if (op[0]) begin
          lo <= in_s1;
        end else begin
          hi <= in_s1;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_DONE_CYC = 1;
  localparam int MUL_BUSY_CYC = 0;
`else
  localparam int MUL_DONE_CYC = 34;
  localparam int MUL_BUSY_CYC = 33;
`endif
  localparam int DIV_DONE_CYC = 34;
  localparam int DIV_BUSY_CYC = 33;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] in_s1, in_s2;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .in_s1       (in_s1),
    .in_s2       (in_s2),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Reference model: plain integer arithmetic on the MIPS definitions.
  task automatic ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
    logic [63:0] p;
    longint      sa, sb;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    rdz = 1'b0;
    rh  = '0;
    rl  = '0;
    case (o)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; end
      3'd1: begin p = sa * sb;                 rh = p[63:32]; rl = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          rdz = 1'b1; rl = 32'hFFFF_FFFF; rh = a;
        end else if (o == 3'd2) begin
          rl = a / b; rh = a % b;
        end else begin
          rl = 32'(sa / sb); rh = 32'(sa % sb);
        end
      end
    endcase
  endtask

  // Called at a negedge: presents a request for exactly one rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; in_s1 = a; in_s2 = b;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Counts negedges after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int cyc, output int bcyc);
    cyc = 0; bcyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      if (busy) bcyc++;
    end while (!done && cyc < 100);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output int bcyc);
    @(negedge clock);
    issue(o, a, b);
    wait_done(cyc, bcyc);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[12];

  int          cyc, bcyc;
  logic [31:0] rh, rl, a, b;
  logic        rdz, done_seen;
  logic [2:0]  o;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{3'd2, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[4]  = '{3'd2, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    vecs[6]  = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[7]  = '{3'd3, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
    vecs[8]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};
    vecs[9]  = '{3'd1, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[10] = '{3'd0, 32'd0,         32'h1234_5678, 32'd0,         32'd0,         1'b0};
    vecs[11] = '{3'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         1'b0};

    reset_n = 1'b0; start = 1'b0; op = 3'd0; in_s1 = '0; in_s2 = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset dz",   32'(div_by_zero), 32'd0);
    check("reset hi",   hi, 32'd0);
    check("reset lo",   lo, 32'd0);
    reset_n = 1'b1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].s1, vecs[i].s2, cyc, bcyc);
      check($sformatf("vec%0d hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d lo", i), lo, vecs[i].exp_lo);
      check($sformatf("vec%0d dz", i), 32'(div_by_zero), 32'(vecs[i].exp_dz));
      check($sformatf("vec%0d done cycle", i), 32'(cyc),
            32'(vecs[i].op[1] ? DIV_DONE_CYC : MUL_DONE_CYC));
      check($sformatf("vec%0d busy cycles", i), 32'(bcyc),
            32'(vecs[i].op[1] ? DIV_BUSY_CYC : MUL_BUSY_CYC));
      @(negedge clock);
      check($sformatf("vec%0d single done", i), 32'(done), 32'd0);
    end

    // Divide by zero, then MTLO/MTHI keep div_by_zero; ignored op 110
    run_op(3'd2, 32'd5, 32'd0, cyc, bcyc);
    check("dz5 flag", 32'(div_by_zero), 32'd1);
    @(negedge clock);
    issue(3'd5, 32'h0000_1234, 32'd0);
    check("mtlo lo", lo, 32'h0000_1234);
    check("mtlo dz held", 32'(div_by_zero), 32'd1);
    check("mtlo busy", 32'(busy), 32'd0);
    @(negedge clock);
    check("mtlo no done", 32'(done), 32'd0);
    issue(3'd4, 32'hABCD_0000, 32'd0);
    check("mthi hi", hi, 32'hABCD_0000);
    @(negedge clock);
    issue(3'd6, 32'h55, 32'h66);
    check("op110 hi", hi, 32'hABCD_0000);
    check("op110 lo", lo, 32'h0000_1234);
    @(negedge clock);
    check("op110 busy", 32'(busy), 32'd0);
    check("op110 done", 32'(done), 32'd0);
    issue(3'd0, 32'd3, 32'd4);
    check("dz cleared on start", 32'(div_by_zero), 32'd0);
    wait_done(cyc, bcyc);
    check("mul3x4 lo", lo, 32'd12);
    check("mul3x4 hi", hi, 32'd0);

    // Old HI/LO visible during RUN, start while busy ignored, back-to-back start
    @(negedge clock);
    issue(3'd4, 32'h1111_1111, 32'd0);
    @(negedge clock);
    issue(3'd5, 32'h2222_2222, 32'd0);
    @(negedge clock);
    issue(3'd2, 32'd100, 32'd7);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clock);
      cyc++;
      start = (cyc == 10); op = 3'd0; in_s1 = '1; in_s2 = '1;
      if (cyc == 16) begin
        check("run hi held", hi, 32'h1111_1111);
        check("run lo held", lo, 32'h2222_2222);
      end
    end
    start = 1'b0;
    check("ignored start cycle", 32'(cyc), 32'(DIV_DONE_CYC));
    check("ignored start lo", lo, 32'd14);
    check("ignored start hi", hi, 32'd2);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    check("b2b busy", 32'(busy), 32'd1);
    check("b2b done low", 32'(done), 32'd0);
    wait_done(cyc, bcyc);
    check("b2b cycle", 32'(cyc), 32'(DIV_DONE_CYC));
    check("b2b lo", lo, 32'hFFFF_FFFD);
    check("b2b hi", hi, 32'hFFFF_FFFF);

    // Reset in the middle of a divide
    @(negedge clock);
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    @(negedge clock);
    issue(3'd5, 32'hCAFE_F00D, 32'd0);
    @(negedge clock);
    issue(3'd3, 32'hFFFF_FF9C, 32'd3);
    done_seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (done) done_seen = 1'b1;
      start = (c == 10); op = 3'd0; in_s1 = 32'd9; in_s2 = 32'd9;
    end
    start = 1'b0;
    check("pre-reset busy", 32'(busy), 32'd1);
    check("pre-reset lo", lo, 32'hCAFE_F00D);
    reset_n = 1'b0;
    #1;
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset hi", hi, 32'd0);
    check("async reset lo", lo, 32'd0);
    check("async reset done", 32'(done), 32'd0);
    repeat (3) begin
      @(negedge clock);
      if (done) done_seen = 1'b1;
    end
    reset_n = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (done) done_seen = 1'b1;
    end
    check("no done around reset", 32'(done_seen), 32'd0);
    check("idle after reset", 32'(busy), 32'd0);

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        default: ;
      endcase
      ref_model(o, a, b, rh, rl, rdz);
      run_op(o, a, b, cyc, bcyc);
      check($sformatf("rnd%0d op%0d hi", i, o), hi, rh);
      check($sformatf("rnd%0d op%0d lo", i, o), lo, rl);
      check($sformatf("rnd%0d op%0d dz", i, o), 32'(div_by_zero), 32'(rdz));
      check($sformatf("rnd%0d op%0d cycle", i, o), 32'(cyc),
            32'(o[1] ? DIV_DONE_CYC : MUL_DONE_CYC));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
